// File: rtl/quad_encoder_ctrl.sv
// Quadrature encoder controller: pin sync/glitch filter, x1/x4 decode into a
// 32-bit position, periodic velocity snapshots, and a small register file.
module quad_encoder_ctrl #(
    parameter int PERIOD_W = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic        wen,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        pinEncoderA,
    input  logic        pinEncoderB,
    output logic        irq
);

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_POSITION = 2'd1;
    localparam logic [1:0] ADDR_PERIOD   = 2'd2;
    localparam logic [1:0] ADDR_VELOCITY = 2'd3;

    logic                a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic                b_s1_q, b_s1_d, b_s2_q, b_s2_d;
    logic                a_filt_q, a_filt_d, b_filt_q, b_filt_d;
    logic [3:0]          a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [1:0]          prev_ab_q, prev_ab_d;
    logic [7:0]          ctrl_q, ctrl_d;
    logic                dec_err_q, dec_err_d;
    logic                irq_pend_q, irq_pend_d;
    logic [31:0]         pos_q, pos_d;
    logic [31:0]         last_snap_q, last_snap_d;
    logic [31:0]         vel_q, vel_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [31:0]         rdata_q, rdata_d;

    logic       enable, x4, invert;
    logic [3:0] filt_len;
    logic [1:0] cur_ab;
    logic       fwd, rev, dbl, cnt_up, cnt_dn, snap, wr, rd;
    logic       unused_wdata;

    assign enable       = ctrl_q[0];
    assign x4           = ctrl_q[1];
    assign invert       = ctrl_q[2];
    assign filt_len     = ctrl_q[7:4];
    assign cur_ab       = {a_filt_q, b_filt_q};
    assign wr           = sel & wen;
    assign rd           = sel & ~wen;
    assign unused_wdata = ^wdata;

    always_comb begin
        a_s1_d      = pinEncoderA;
        a_s2_d      = a_s1_q;
        b_s1_d      = pinEncoderB;
        b_s2_d      = b_s1_q;
        a_filt_d    = a_filt_q;
        a_cnt_d     = a_cnt_q;
        b_filt_d    = b_filt_q;
        b_cnt_d     = b_cnt_q;
        prev_ab_d   = cur_ab;
        ctrl_d      = ctrl_q;
        dec_err_d   = dec_err_q;
        irq_pend_d  = irq_pend_q;
        pos_d       = pos_q;
        last_snap_d = last_snap_q;
        vel_d       = vel_q;
        period_d    = period_q;
        timer_d     = timer_q;
        rdata_d     = rdata_q;
        fwd         = 1'b0;
        rev         = 1'b0;
        dbl         = 1'b0;
        cnt_up      = 1'b0;
        cnt_dn      = 1'b0;
        snap        = 1'b0;

        // A new level is accepted only after it persists filt_len+1 cycles
        if (a_s2_q == a_filt_q) begin
            a_cnt_d = 4'd0;
        end else if (a_cnt_q == filt_len) begin
            a_filt_d = a_s2_q;
            a_cnt_d  = 4'd0;
        end else begin
            a_cnt_d = a_cnt_q + 4'd1;
        end
        if (b_s2_q == b_filt_q) begin
            b_cnt_d = 4'd0;
        end else if (b_cnt_q == filt_len) begin
            b_filt_d = b_s2_q;
            b_cnt_d  = 4'd0;
        end else begin
            b_cnt_d = b_cnt_q + 4'd1;
        end

        case ({prev_ab_q, cur_ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: dbl = 1'b1;
            default: ;
        endcase

        if (enable) begin
            if (x4) begin
                cnt_up = fwd;
                cnt_dn = rev;
            end else begin
                // x1 counts only on the rising edge of A
                cnt_up = fwd & ~prev_ab_q[1] & cur_ab[1];
                cnt_dn = rev & ~prev_ab_q[1] & cur_ab[1];
            end
            if (invert) begin
                {cnt_up, cnt_dn} = {cnt_dn, cnt_up};
            end
        end

        if (cnt_up) begin
            pos_d = pos_q + 32'd1;
        end else if (cnt_dn) begin
            pos_d = pos_q - 32'd1;
        end

        if (!enable || period_q == '0) begin
            timer_d = '0;
        end else if (timer_q == period_q - {{(PERIOD_W-1){1'b0}}, 1'b1}) begin
            snap        = 1'b1;
            timer_d     = '0;
            vel_d       = pos_q - last_snap_q;
            last_snap_d = pos_q;
        end else begin
            timer_d = timer_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
        end

        if (wr) begin
            case (addr)
                ADDR_CTRL: begin
                    ctrl_d = wdata[7:0];
                    if (wdata[30]) dec_err_d = 1'b0;
                    if (wdata[31]) irq_pend_d = 1'b0;
                end
                ADDR_POSITION: begin
                    pos_d       = wdata;
                    last_snap_d = wdata;
                end
                ADDR_PERIOD: begin
                    period_d = wdata[PERIOD_W-1:0];
                    timer_d  = '0;
                end
                default: ;
            endcase
        end

        // Hardware set wins over a same-cycle W1C
        if (dbl)  dec_err_d  = 1'b1;
        if (snap) irq_pend_d = 1'b1;

        if (rd) begin
            case (addr)
                ADDR_CTRL:     rdata_d = {irq_pend_q, dec_err_q, 22'd0, ctrl_q};
                ADDR_POSITION: rdata_d = pos_q;
                ADDR_PERIOD:   rdata_d = {{(32-PERIOD_W){1'b0}}, period_q};
                ADDR_VELOCITY: rdata_d = vel_q;
                default:       rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_s1_q      <= 1'b0;
            a_s2_q      <= 1'b0;
            b_s1_q      <= 1'b0;
            b_s2_q      <= 1'b0;
            a_filt_q    <= 1'b0;
            b_filt_q    <= 1'b0;
            a_cnt_q     <= 4'd0;
            b_cnt_q     <= 4'd0;
            prev_ab_q   <= 2'b00;
            ctrl_q      <= 8'd0;
            dec_err_q   <= 1'b0;
            irq_pend_q  <= 1'b0;
            pos_q       <= 32'd0;
            last_snap_q <= 32'd0;
            vel_q       <= 32'd0;
            period_q    <= '0;
            timer_q     <= '0;
            rdata_q     <= 32'd0;
        end else begin
            a_s1_q      <= a_s1_d;
            a_s2_q      <= a_s2_d;
            b_s1_q      <= b_s1_d;
            b_s2_q      <= b_s2_d;
            a_filt_q    <= a_filt_d;
            b_filt_q    <= b_filt_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            prev_ab_q   <= prev_ab_d;
            ctrl_q      <= ctrl_d;
            dec_err_q   <= dec_err_d;
            irq_pend_q  <= irq_pend_d;
            pos_q       <= pos_d;
            last_snap_q <= last_snap_d;
            vel_q       <= vel_d;
            period_q    <= period_d;
            timer_q     <= timer_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_pend_q & ctrl_q[3];

endmodule

// File: doc/quad_encoder_ctrl.md
# quad_encoder_ctrl

Register-mapped controller for one quadrature motor encoder: synchronizes and glitch-filters the A/B pins, decodes them in x1 or x4 mode into a 32-bit position counter, and takes periodic velocity snapshots on a programmable timer. It sits between the CPU peripheral bus and the encoder pins. It also owns preset of the count (write-to-position), sticky error and interrupt status.

## Interface
- PERIOD_W, 24: width of the velocity sample-period register and timer.
- clk  in  1  system clock; all logic rises on posedge.
- resetn  in  1  asynchronous, active-low reset.
- sel  in  1  bus access strobe, one cycle per access.
- wen  in  1  1 = write, 0 = read (qualified by sel).
- addr  in  2  register select: 0 CTRL, 1 POSITION, 2 PERIOD, 3 VELOCITY.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- pinEncoderA  in  1  encoder channel A, asynchronous.
- pinEncoderB  in  1  encoder channel B, asynchronous.
- irq  out  1  level interrupt = irq_pending & irq_en.

## Operation
- CTRL fields:
  - bit0 enable.
  - bit1 x4 (0 = x1).
  - bit2 invert direction.
  - bit3 irq_en.
  - bits7:4 filt_len.
  - bit30 decode_error (sticky, W1C).
  - bit31 irq_pending (W1C).
  - Other bits read 0.
- Writing CTRL: bits 7:0 load; a 1 in bit 30 or 31 clears that flag.
- Synchronizer: two flops per pin (s1, s2).
- Filter, per pin: filt/cnt pair (cnt 4 bits).
  - s2 == filt: cnt <= 0.
  - Otherwise, if cnt == filt_len: filt <= s2 and cnt <= 0; else cnt++.
  - Always runs, even when disabled.
- Decoder: compares {A,B} filtered state against a registered previous state each cycle.
  - Forward sequence: 00 -> 10 -> 11 -> 01 -> 00 (A leads).
  - x4: every valid forward step +1, every reverse step -1.
  - x1: count only on filtered A rising edge; +1 if B = 0, -1 if B = 1.
  - Both bits changing in one cycle: no count, set decode_error.
  - invert negates the step.
  - When enable = 0, the step is suppressed but the previous state still updates, so re-enable gives no spurious count.
- Position: 32-bit, wraps modulo 2^32 in both directions.
  - Write to POSITION loads wdata and also loads last_snap <= wdata, so there is no velocity jump.
  - A write discards any decode step in the same cycle.
- Velocity timer:
  - Runs only when enable = 1 and PERIOD != 0; otherwise held at 0.
  - When timer == PERIOD-1: VELOCITY <= position - last_snap (signed 32, wrapping subtraction of pre-edge values), last_snap <= position, timer <= 0, irq_pending <= 1.
  - Preset in the same cycle overrides last_snap only.
  - Writing PERIOD resets the timer to 0.
- Writes to VELOCITY are ignored. Accesses with sel = 0 have no effect.
- Simultaneous W1C and a new snapshot in the same cycle: irq_pending stays set (set wins).

## Timing
- Reset values: all registers, counters, filter state and the synchronizer are 0; rdata = 0, irq = 0.
- Pin-to-position latency: 4 + filt_len clock edges after the pin change is first sampled (sync 2, filter 1 + filt_len, decode 1).
- A pin pulse shorter than filt_len + 1 cycles after synchronization is rejected.
- Read: rdata is valid on the edge after the sel & !wen cycle and holds until the next read.
- Writes take effect at the edge of the sel & wen cycle; a read in the next cycle returns the new value.
- irq follows irq_pending / irq_en combinationally from registered state.
- resetn asserted mid-operation clears everything immediately; position restarts at 0 after release.

## Test plan
- Reset, then read all four addresses -> all 0; irq = 0.
- CTRL = 0x03, filt_len 0; drive AB 00, 10, 11, 01, 00, each held 8 cycles -> POSITION = 4. Reverse the sequence -> 0. One more reverse step -> 0xFFFFFFFF.
- CTRL = 0x01 (x1): one full forward cycle -> POSITION = 1. Set invert (0x05) and repeat -> 0.
- filt_len = 3: 3-cycle glitch on A -> no count. A stable high with B = 0 -> POSITION increments exactly 7 cycles after the first sampled edge.
- PERIOD = 100, CTRL = 0x0B: 10 forward x4 steps inside one period -> VELOCITY = 10, irq = 1. Write CTRL bit31 -> irq = 0. Preset POSITION = 1000 mid-period with no motion -> next VELOCITY = 0.
- AB 00 -> 11 in one step -> POSITION unchanged, CTRL bit30 = 1; W1C clears it. Preset write coinciding with a decode step -> POSITION = written value.
